// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: client (fetch / memory stage) and backing-memory signals
// of the memory arbiter, bundled into one interface.
//   slave  : the arbiter's view (requests and memory responses in, readies and memory commands out)
//   master : the environment's view (pipeline stages plus memory model)
interface mem_arbiter_if;
  // Fetch (I) client
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ready;
  logic [15:0] i_rdata;
  // Memory-stage (D) client
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ready;
  logic [15:0] d_rdata;
  // Backing memory
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  // Sticky error flag
  logic        err;

  modport slave (
    input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_done,
    output i_ready, i_rdata, d_ready, d_rdata, mem_req, mem_wr, mem_addr, mem_wdata, err
  );

  modport master (
    output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_done,
    input  i_ready, i_rdata, d_ready, d_rdata, mem_req, mem_wr, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported multi-cycle memory between the fetch
// (I) and memory (D) pipeline stages. D has priority; a starvation counter
// forces an I grant after STARVE_LIMIT consecutive D grants while I waits.
// Each served client gets a one-cycle registered ready pulse with its data.
//
// Optional feature macro: MEMARB_TIMEOUT_EN
//   defined   : a 6-bit wait counter aborts an access after WAIT_MAX cycles
//               without mem_done, sets err and returns 16'hFFFF.
//   undefined : the arbiter waits for mem_done indefinitely.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
`ifdef MEMARB_TIMEOUT_EN
  ,
  parameter int unsigned WAIT_MAX     = 63
`endif
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
`ifdef MEMARB_TIMEOUT_EN
  localparam logic [5:0] WAIT_LAST  = 6'(WAIT_MAX - 1);
`endif

  state_e      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;
  logic        drop_q, drop_d;
`ifdef MEMARB_TIMEOUT_EN
  logic [5:0]  wait_q, wait_d;
`endif

  logic        d_req_s;
  logic        d_win_s;
  logic        owner_req_s;
  logic        owner_ok_s;
  logic        grant_i_s;
  logic        grant_d_s;
  logic        finish_s;
  logic [15:0] finish_data_s;

  // D wins unless I has already waited through STARVE_LIMIT D grants.
  assign d_req_s     = bus.d_rd | bus.d_wr;
  assign d_win_s     = d_req_s && ((starve_q < STARVE_MAX) || !bus.i_req);
  assign owner_req_s = (state_q == ST_GRANT_I) ? bus.i_req : d_req_s;
  // A client that dropped its request at any point of the access gets no ready.
  assign owner_ok_s  = owner_req_s && !drop_q;

  // Next-state, grant and response logic. RESP arbitrates like IDLE so that
  // back-to-back accesses need no idle cycle; a request still high during a
  // ready cycle is taken as the client's next request.
  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    mem_req_d     = mem_req_q;
    mem_wr_d      = mem_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    i_ready_d     = 1'b0;
    d_ready_d     = 1'b0;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    err_d         = err_q;
    drop_d        = drop_q;
    grant_i_s     = 1'b0;
    grant_d_s     = 1'b0;
    finish_s      = 1'b0;
    finish_data_s = 16'h0000;
`ifdef MEMARB_TIMEOUT_EN
    wait_d        = wait_q;
`endif

    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        drop_d  = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
        wait_d  = 6'd0;
`endif
        if (d_win_s) begin
          grant_d_s = 1'b1;
          if (bus.d_addr[0]) begin
            // Misaligned: no memory access, answer straight away with zero data.
            state_d   = ST_RESP;
            d_ready_d = 1'b1;
            d_rdata_d = 16'h0000;
            err_d     = 1'b1;
            mem_req_d = 1'b0;
          end else begin
            state_d     = ST_GRANT_D;
            mem_req_d   = 1'b1;
            mem_wr_d    = bus.d_wr;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end
        end else if (bus.i_req) begin
          grant_i_s   = 1'b1;
          state_d     = ST_GRANT_I;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = bus.i_addr;
          mem_wdata_d = 16'h0000;
        end else begin
          mem_req_d = 1'b0;
        end
      end

      ST_GRANT_I, ST_GRANT_D: begin
        if (!owner_req_s) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end

        if (bus.mem_done) begin
          finish_s      = 1'b1;
          finish_data_s = bus.mem_rdata;
`ifdef MEMARB_TIMEOUT_EN
        end else if (wait_q == WAIT_LAST) begin
          finish_s      = 1'b1;
          finish_data_s = 16'hFFFF;
          err_d         = 1'b1;
        end else begin
          wait_d = wait_q + 6'd1;
`else
        end else begin
          finish_s = 1'b0;
`endif
        end

        if (finish_s) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (state_q == ST_GRANT_I) begin
            i_ready_d = owner_ok_s;
            i_rdata_d = finish_data_s;
          end else begin
            d_ready_d = owner_ok_s;
            d_rdata_d = finish_data_s;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Starvation count: D grants while I waits; cleared by an I grant or idle I.
    if (!bus.i_req) begin
      starve_d = 3'd0;
    end else if (grant_i_s) begin
      starve_d = 3'd0;
    end else if (grant_d_s && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + 3'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // State and output registers; asynchronous reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= 3'd0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= 16'h0000;
      d_rdata_q   <= 16'h0000;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
      wait_q      <= 6'd0;
`endif
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
`ifdef MEMARB_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;

endmodule
